// File: rtl/cu_issue_pkg.sv
// Shared definitions for the compute-unit issue controller: unit codes, instruction
// field positions, result-select bit indices, FSM encoding and the decoded control bundle.
package cu_pkg;

    typedef enum logic [1:0] {
        UNIT_NOP = 2'b00,
        UNIT_ALU = 2'b01,
        UNIT_MUL = 2'b10,
        UNIT_SHF = 2'b11
    } unit_e;

    localparam int UNIT_HI = 31;
    localparam int UNIT_LO = 30;
    localparam int FUNC_HI = 29;
    localparam int FUNC_LO = 20;
    localparam int RSV_HI  = 19;
    localparam int RSV_LO  = 12;
    localparam int RN_LO   = 8;
    localparam int RX_LO   = 4;
    localparam int RY_LO   = 0;
    localparam int REG_W   = 4;

    localparam int CUEN_ALU = 0;
    localparam int CUEN_MUL = 1;
    localparam int CUEN_SHF = 2;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_MUL2 = 1'b1;

    typedef struct packed {
        logic       alu_log;
        logic [1:0] alu_hc;
        logic [2:0] alu_sc;
        logic       alu_sat;
        logic       mul_otreg;
        logic [3:0] mul_dtsts;
        logic [1:0] mul_cls;
        logic [1:0] shf_cls;
    } ctrl_t;

endpackage

// File: rtl/cu_issue_decode.sv
// Combinational instruction decode: register fields, effective unit and per-unit controls.
// Fields belonging to a unit other than the decoded one are forced to zero.
module cu_issue_decode
    import cu_pkg::*;
(
    input  logic [31:0]      i_instr,
    output unit_e            o_unit,
    output logic             o_illegal,
    output logic [REG_W-1:0] o_rn,
    output logic [REG_W-1:0] o_rx,
    output logic [REG_W-1:0] o_ry,
    output ctrl_t            o_ctrl
);

    logic [6:0] w_func;
    logic       w_unused_func;
    unit_e      w_raw_unit;

    assign w_raw_unit    = unit_e'(i_instr[UNIT_HI:UNIT_LO]);
    assign w_func        = i_instr[FUNC_LO +: 7];
    assign w_unused_func = ^i_instr[FUNC_HI:FUNC_LO+7];

    // Malformed words still flow down the pipe, but as a NOP.
    assign o_illegal = |i_instr[RSV_HI:RSV_LO];
    assign o_unit    = o_illegal ? UNIT_NOP : w_raw_unit;

    assign o_rn = i_instr[RN_LO +: REG_W];
    assign o_rx = i_instr[RX_LO +: REG_W];
    assign o_ry = i_instr[RY_LO +: REG_W];

    always_comb begin
        o_ctrl = '0;
        case (o_unit)
            UNIT_ALU: begin
                o_ctrl.alu_log = w_func[0];
                o_ctrl.alu_hc  = w_func[2:1];
                o_ctrl.alu_sc  = w_func[5:3];
                o_ctrl.alu_sat = w_func[6];
            end
            UNIT_MUL: begin
                o_ctrl.mul_otreg = w_func[0];
                o_ctrl.mul_dtsts = w_func[4:1];
                o_ctrl.mul_cls   = w_func[6:5];
            end
            UNIT_SHF: begin
                o_ctrl.shf_cls = w_func[1:0];
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cu_issue.sv
// Issue controller: accept -> execute -> write-back, MUL holds E for two cycles.
// Define CU_ISSUE_INTERLOCK_EN to stall acceptance on RAW hazards against E and W.
module cu_issue
    import cu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 4,
    parameter int SIGNAL_WIDTH  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              ps_cu_instr,
    input  logic                     ps_cu_valid,
    output logic                     cu_ps_ready,
    output logic                     cu_ps_illegal,
    output logic                     ps_alu_en,
    output logic                     ps_alu_log,
    output logic                     ps_alu_sat,
    output logic [1:0]               ps_alu_hc,
    output logic [2:0]               ps_alu_sc,
    output logic                     ps_mul_en,
    output logic                     ps_mul_otreg,
    output logic [3:0]               ps_mul_dtsts,
    output logic [1:0]               ps_mul_cls,
    output logic                     ps_shf_en,
    output logic [1:0]               ps_shf_cls,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddx,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_raddy,
    output logic [ADDRESS_WIDTH-1:0] ps_xb_wadd,
    output logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn
);

    unit_e                   w_dec_unit;
    logic                    w_dec_illegal;
    logic [REG_W-1:0]        w_rn;
    logic [REG_W-1:0]        w_rx;
    logic [REG_W-1:0]        w_ry;
    ctrl_t                   w_dec_ctrl;
    logic                    w_accept;
    logic                    w_hazard;
    logic                    w_e_busy;
    logic [SIGNAL_WIDTH-1:0] w_e_cuen;

    logic [0:0]               r_state;
    logic                     r_illegal;
    logic                     r_alu_en;
    logic                     r_mul_en;
    logic                     r_shf_en;
    ctrl_t                    r_ctrl;
    logic [ADDRESS_WIDTH-1:0] r_raddx;
    logic [ADDRESS_WIDTH-1:0] r_raddy;
    logic [ADDRESS_WIDTH-1:0] r_wadd;
    logic [SIGNAL_WIDTH-1:0]  r_w_cuen;
    logic [REG_W-1:0]         r_e_rn;

    cu_issue_decode u_decode (
        .i_instr   (ps_cu_instr),
        .o_unit    (w_dec_unit),
        .o_illegal (w_dec_illegal),
        .o_rn      (w_rn),
        .o_rx      (w_rx),
        .o_ry      (w_ry),
        .o_ctrl    (w_dec_ctrl)
    );

    always_comb begin
        w_e_cuen           = '0;
        w_e_cuen[CUEN_ALU] = r_alu_en;
        w_e_cuen[CUEN_MUL] = r_mul_en;
        w_e_cuen[CUEN_SHF] = r_shf_en;
    end

    assign w_e_busy = |w_e_cuen;

`ifdef CU_ISSUE_INTERLOCK_EN
    logic w_src_live;
    logic w_e_hit;
    logic w_w_hit;

    assign w_src_live = unit_e'(ps_cu_instr[UNIT_HI:UNIT_LO]) != UNIT_NOP;
    assign w_e_hit    = w_e_busy && ((w_rx == r_e_rn) || (w_ry == r_e_rn));
    // W's destination is exactly what is being presented on ps_xb_wadd.
    assign w_w_hit    = (|r_w_cuen) && ((ADDRESS_WIDTH'(w_rx) == r_wadd) ||
                                        (ADDRESS_WIDTH'(w_ry) == r_wadd));
    assign w_hazard   = w_src_live && (w_e_hit || w_w_hit);
`else
    assign w_hazard = 1'b0;
`endif

    // Gating with reset keeps ready low in reset and high right after release.
    assign cu_ps_ready = reset && (r_state == ST_RUN) && !w_hazard;
    assign w_accept    = ps_cu_valid && cu_ps_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_illegal <= 1'b0;
            r_alu_en  <= 1'b0;
            r_mul_en  <= 1'b0;
            r_shf_en  <= 1'b0;
            r_ctrl    <= '0;
            r_raddx   <= '0;
            r_raddy   <= '0;
            r_wadd    <= '0;
            r_w_cuen  <= '0;
            r_e_rn    <= '0;
        end else begin
            r_illegal <= w_accept && w_dec_illegal;
            if (r_state == ST_MUL2) begin
                // Second MUL execute cycle: E contents held, nothing retires yet.
                r_state  <= ST_RUN;
                r_w_cuen <= '0;
            end else begin
                r_w_cuen <= w_e_cuen;
                if (w_e_busy) begin
                    r_wadd <= ADDRESS_WIDTH'(r_e_rn);
                end
                r_alu_en <= w_accept && (w_dec_unit == UNIT_ALU);
                r_mul_en <= w_accept && (w_dec_unit == UNIT_MUL);
                r_shf_en <= w_accept && (w_dec_unit == UNIT_SHF);
                r_ctrl   <= w_accept ? w_dec_ctrl : '0;
                if (w_accept && (w_dec_unit != UNIT_NOP)) begin
                    r_raddx <= ADDRESS_WIDTH'(w_rx);
                    r_raddy <= ADDRESS_WIDTH'(w_ry);
                    r_e_rn  <= w_rn;
                end
                r_state <= (w_accept && (w_dec_unit == UNIT_MUL)) ? ST_MUL2 : ST_RUN;
            end
        end
    end

    assign cu_ps_illegal = r_illegal;
    assign ps_alu_en     = r_alu_en;
    assign ps_alu_log    = r_ctrl.alu_log;
    assign ps_alu_sat    = r_ctrl.alu_sat;
    assign ps_alu_hc     = r_ctrl.alu_hc;
    assign ps_alu_sc     = r_ctrl.alu_sc;
    assign ps_mul_en     = r_mul_en;
    assign ps_mul_otreg  = r_ctrl.mul_otreg;
    assign ps_mul_dtsts  = r_ctrl.mul_dtsts;
    assign ps_mul_cls    = r_ctrl.mul_cls;
    assign ps_shf_en     = r_shf_en;
    assign ps_shf_cls    = r_ctrl.shf_cls;
    assign ps_xb_raddx   = r_raddx;
    assign ps_xb_raddy   = r_raddy;
    assign ps_xb_wadd    = r_wadd;
    assign ps_xb_w_cuEn  = r_w_cuen;

endmodule

// File: tb/tb_cu_issue.sv
// Bench for cu_issue: per-cycle comparison against a schedule-based model plus directed literals.
module tb_cu_issue;

    localparam int AW   = 4;
    localparam int SW   = 3;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   ps_cu_instr = 32'h0;
    logic          ps_cu_valid = 1'b0;
    logic          cu_ps_ready, cu_ps_illegal;
    logic          ps_alu_en, ps_alu_log, ps_alu_sat;
    logic [1:0]    ps_alu_hc;
    logic [2:0]    ps_alu_sc;
    logic          ps_mul_en, ps_mul_otreg;
    logic [3:0]    ps_mul_dtsts;
    logic [1:0]    ps_mul_cls;
    logic          ps_shf_en;
    logic [1:0]    ps_shf_cls;
    logic [AW-1:0] ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
    logic [SW-1:0] ps_xb_w_cuEn;

    cu_issue #(.ADDRESS_WIDTH(AW), .SIGNAL_WIDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .ps_cu_instr(ps_cu_instr), .ps_cu_valid(ps_cu_valid),
        .cu_ps_ready(cu_ps_ready), .cu_ps_illegal(cu_ps_illegal),
        .ps_alu_en(ps_alu_en), .ps_alu_log(ps_alu_log), .ps_alu_sat(ps_alu_sat),
        .ps_alu_hc(ps_alu_hc), .ps_alu_sc(ps_alu_sc),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
        .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls),
        .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
        .ps_xb_raddx(ps_xb_raddx), .ps_xb_raddy(ps_xb_raddy),
        .ps_xb_wadd(ps_xb_wadd), .ps_xb_w_cuEn(ps_xb_w_cuEn)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Schedule: which instruction sits in E / W in a given cycle, illegal pulses, MUL stalls.
    bit          e_ok [MAXC];
    logic [31:0] e_ins[MAXC];
    bit          w_ok [MAXC];
    logic [31:0] w_ins[MAXC];
    bit          ill  [MAXC];
    bit          blk  [MAXC];
    bit [3:0]    m_rx, m_ry, m_wn;
    bit          acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit hazard(input logic [31:0] ins);
        if (ins[31:30] == 2'b00) return 1'b0;
`ifdef CU_ISSUE_INTERLOCK_EN
        if (e_ok[cyc] && (ins[7:4] == e_ins[cyc][11:8] || ins[3:0] == e_ins[cyc][11:8])) return 1'b1;
        if (w_ok[cyc] && (ins[7:4] == w_ins[cyc][11:8] || ins[3:0] == w_ins[cyc][11:8])) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic check_outputs();
        logic [31:0] ei, wi;
        logic [1:0]  u, uw;
        logic [9:0]  f;
        ei = e_ok[cyc] ? e_ins[cyc] : 32'h0;
        u  = ei[31:30];
        f  = ei[29:20];
        if (e_ok[cyc]) begin m_rx = ei[7:4]; m_ry = ei[3:0]; end
        wi = w_ok[cyc] ? w_ins[cyc] : 32'h0;
        uw = wi[31:30];
        if (w_ok[cyc]) m_wn = wi[11:8];
        chk("illegal",   cu_ps_illegal, ill[cyc]);
        chk("alu_en",    ps_alu_en,    u == 2'd1);
        chk("alu_log",   ps_alu_log,   (u == 2'd1) ? f[0]   : 1'b0);
        chk("alu_hc",    ps_alu_hc,    (u == 2'd1) ? f[2:1] : 2'd0);
        chk("alu_sc",    ps_alu_sc,    (u == 2'd1) ? f[5:3] : 3'd0);
        chk("alu_sat",   ps_alu_sat,   (u == 2'd1) ? f[6]   : 1'b0);
        chk("mul_en",    ps_mul_en,    u == 2'd2);
        chk("mul_otreg", ps_mul_otreg, (u == 2'd2) ? f[0]   : 1'b0);
        chk("mul_dtsts", ps_mul_dtsts, (u == 2'd2) ? f[4:1] : 4'd0);
        chk("mul_cls",   ps_mul_cls,   (u == 2'd2) ? f[6:5] : 2'd0);
        chk("shf_en",    ps_shf_en,    u == 2'd3);
        chk("shf_cls",   ps_shf_cls,   (u == 2'd3) ? f[1:0] : 2'd0);
        chk("raddx",     ps_xb_raddx,  m_rx);
        chk("raddy",     ps_xb_raddy,  m_ry);
        chk("wadd",      ps_xb_wadd,   m_wn);
        chk("cuen",      ps_xb_w_cuEn, w_ok[cyc] ? (3'b001 << (uw - 2'd1)) : 3'b000);
    endtask

    task automatic step(input bit v, input logic [31:0] ins);
        bit         exp_rdy, legal;
        logic [1:0] eu;
        int         c;
        ps_cu_valid = v;
        ps_cu_instr = ins;
        #1;
        check_outputs();
        exp_rdy = !blk[cyc] && !hazard(ins);
        chk("ready", cu_ps_ready, exp_rdy);
        acc = v && exp_rdy;
        c = cyc;
        if (acc) begin
            legal = (ins[19:12] == 8'h00);
            eu = legal ? ins[31:30] : 2'b00;
            ill[c+1] = !legal;
            if (eu != 2'b00) begin
                e_ok[c+1] = 1'b1; e_ins[c+1] = ins;
                if (eu == 2'b10) begin
                    e_ok[c+2] = 1'b1; e_ins[c+2] = ins;
                    w_ok[c+3] = 1'b1; w_ins[c+3] = ins;
                    blk[c+1]  = 1'b1;
                end else begin
                    w_ok[c+2] = 1'b1; w_ins[c+2] = ins;
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic clear_model();
        for (int i = cyc; i < cyc + 5; i++) begin
            e_ok[i] = 1'b0; w_ok[i] = 1'b0; ill[i] = 1'b0; blk[i] = 1'b0;
        end
        m_rx = 4'd0; m_ry = 4'd0; m_wn = 4'd0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ready"}, cu_ps_ready, 1'b0);
        chk({nm, "_illegal"}, cu_ps_illegal, 1'b0);
        chk({nm, "_en"}, {ps_alu_en, ps_mul_en, ps_shf_en}, 3'b000);
        chk({nm, "_ctrl"}, {ps_alu_log, ps_alu_sat, ps_alu_hc, ps_alu_sc, ps_mul_otreg,
                            ps_mul_dtsts, ps_mul_cls, ps_shf_cls}, 18'h0);
        chk({nm, "_addr"}, {ps_xb_raddx, ps_xb_raddy, ps_xb_wadd}, 12'h0);
        chk({nm, "_cuen"}, ps_xb_w_cuEn, 3'b000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int got_at;
        logic [31:0] ins;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("rst");
        reset = 1'b1;
        #1;
        chk("rdy_after_rst", cu_ps_ready, 1'b1);
        chk("cuen_after_rst", ps_xb_w_cuEn, 3'b000);
        @(negedge clk);

        // ALU issue
        drain(3);
        step(1'b1, 32'h4000_0123);
        chk("alu_acc", acc, 1'b1);
        chk("alu_t1_en", ps_alu_en, 1'b1);
        chk("alu_t1_rx", ps_xb_raddx, 4'd2);
        chk("alu_t1_ry", ps_xb_raddy, 4'd3);
        step(1'b0, 32'h0);
        chk("alu_t2_cuen", ps_xb_w_cuEn, 3'b001);
        chk("alu_t2_wadd", ps_xb_wadd, 4'd1);

        // MUL issue
        drain(3);
        step(1'b1, 32'h8000_0456);
        chk("mul_acc", acc, 1'b1);
        chk("mul_t1_en", ps_mul_en, 1'b1);
        chk("mul_t1_ready", cu_ps_ready, 1'b0);
        step(1'b0, 32'h0);
        chk("mul_t2_en", ps_mul_en, 1'b1);
        chk("mul_t2_cuen", ps_xb_w_cuEn, 3'b000);
        step(1'b0, 32'h0);
        chk("mul_t3_cuen", ps_xb_w_cuEn, 3'b010);
        chk("mul_t3_wadd", ps_xb_wadd, 4'd4);

        // RAW hazard: producer rn=5 then consumer rx=5
        drain(3);
        step(1'b1, 32'h4000_0500);
        chk("raw_prod_acc", acc, 1'b1);
        got_at = -1;
        for (int k = 0; k < 6 && got_at < 0; k++) begin
            step(1'b1, 32'h4000_0150);
            if (acc) got_at = k;
        end
`ifdef CU_ISSUE_INTERLOCK_EN
        chk("raw_accept_slot", got_at, 2);
`else
        chk("raw_accept_slot", got_at, 0);
`endif

        // Malformed instruction
        drain(3);
        step(1'b1, 32'h4000_1123);
        chk("ill_acc", acc, 1'b1);
        chk("ill_pulse", cu_ps_illegal, 1'b1);
        chk("ill_no_en", {ps_alu_en, ps_mul_en, ps_shf_en}, 3'b000);
        step(1'b0, 32'h0);
        chk("ill_pulse_end", cu_ps_illegal, 1'b0);
        chk("ill_w_cuen", ps_xb_w_cuEn, 3'b000);

        // SHF streaming throughput
        drain(3);
        for (int i = 0; i < 16; i++) begin
            ins = 32'hC000_0000 | ((8 + i % 8) << 8) | ((i % 8) << 4) | ((i + 3) % 8);
            step(1'b1, ins);
            chk("shf_acc", acc, 1'b1);
            chk("shf_en_run", ps_shf_en, 1'b1);
        end
        step(1'b0, 32'h0);
        chk("shf_last_cuen", ps_xb_w_cuEn, 3'b100);

        // Reset in the middle of a MUL
        drain(3);
        step(1'b1, 32'h8000_0789);
        chk("mrst_acc", acc, 1'b1);
        reset = 1'b0;
        ps_cu_valid = 1'b0;
        #1;
        chk_zero("mrst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        #1;
        chk("mrst_rdy_release", cu_ps_ready, 1'b1);
        chk("mrst_cuen_release", ps_xb_w_cuEn, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0);
            chk("mrst_no_wb", ps_xb_w_cuEn, 3'b000);
        end

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[19:12] = 8'h00;
            if ($urandom_range(0, 1) != 0) begin
                ins[11] = 1'b0; ins[7] = 1'b0; ins[3] = 1'b0;
            end
            step($urandom_range(0, 3) != 0, ins);
        end
        drain(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
